// File: rtl/cpu_types_pkg.sv
// Shared types for the writeback/commit stage: lane bundle, history entry and FSM state.
package cpu_types_pkg;

  localparam int CPU_XLEN = 64;

  typedef logic [CPU_XLEN-1:0] double_word;
  typedef logic [4:0]          reg_idx_t;

  typedef struct packed {
    logic       valid;
    double_word result;
    double_word result_plus_4;
    logic       is_branch;
    logic       write_rd;
    reg_idx_t   rd;
    logic       end_program;
  } wb_lane_t;

  typedef struct packed {
    logic       valid;
    reg_idx_t   rd;
    double_word data;
  } bypass_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_lane_resolver.sv
// Combinational lane resolution: squash after the first branch/end lane, drop
// writes shadowed by a younger lane with the same rd, and select the PC redirect.
module wb_lane_resolver
  import cpu_types_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  wb_lane_t [NUM_LANES-1:0] lanes,
  input  logic                     commit,
  output logic     [NUM_LANES-1:0] we,
  output reg_idx_t [NUM_LANES-1:0] waddr,
  output double_word [NUM_LANES-1:0] wdata,
  output logic                     pc_write_en,
  output double_word               pc_write,
  output logic                     end_hit,
  output logic     [NUM_LANES-1:0] survive
);

  logic           blocked;
  logic           redirect;
  logic           end_raw;
  double_word     tgt;
  logic [NUM_LANES-1:0] wr_ok;

  always_comb begin
    // NOTE: blocking assignments here let 'blocked' carry the squash decision
    // from older lanes to younger ones within a single evaluation; every
    // variable gets a default first so no latch is inferred.
    survive  = '0;
    blocked  = 1'b0;
    redirect = 1'b0;
    end_raw  = 1'b0;
    tgt      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      survive[i] = lanes[i].valid && !blocked;
      if (survive[i] && (lanes[i].is_branch || lanes[i].end_program)) begin
        blocked  = 1'b1;
        redirect = lanes[i].is_branch;
        end_raw  = lanes[i].end_program;
        tgt      = lanes[i].result;
      end
    end

    wr_ok = '0;
    for (int i = 0; i < NUM_LANES; i++)
      wr_ok[i] = survive[i] && lanes[i].write_rd && (lanes[i].rd != '0);
    // A younger surviving lane to the same rd wins; the older write is dropped.
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = 0; j < NUM_LANES; j++)
        if (j > i && wr_ok[j] && lanes[j].rd == lanes[i].rd) wr_ok[i] = 1'b0;

    we = commit ? wr_ok : '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      waddr[i] = we[i] ? lanes[i].rd : '0;
      wdata[i] = !we[i] ? '0 :
                 lanes[i].is_branch ? lanes[i].result_plus_4 : lanes[i].result;
    end

    pc_write_en = commit && redirect;
    pc_write    = pc_write_en ? {tgt[CPU_XLEN-1:1], 1'b0} : '0;
    end_hit     = commit && end_raw;
  end

endmodule

// File: rtl/writeback_commit_stage.sv
// Multi-lane writeback/commit stage: one-entry stage register, RUN/DONE FSM and
// committed-write history. Optional retired-lane counter under WB_RETIRE_COUNT_EN.
module writeback_commit_stage
  import cpu_types_pkg::*;
#(
  parameter int XLEN         = CPU_XLEN,
  parameter int NUM_LANES    = 2,
  parameter int BYPASS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_LANES-1:0]         in_lane_valid,
  input  logic [NUM_LANES*XLEN-1:0]    in_result,
  input  logic [NUM_LANES*XLEN-1:0]    in_result_plus_4,
  input  logic [NUM_LANES-1:0]         in_is_branch,
  input  logic [NUM_LANES-1:0]         in_write_rd,
  input  logic [NUM_LANES*5-1:0]       in_rd,
  input  logic [NUM_LANES-1:0]         in_end_program,
  input  logic                         rf_grant,
  output logic [NUM_LANES-1:0]         rf_we,
  output logic [NUM_LANES*5-1:0]       rf_waddr,
  output logic [NUM_LANES*XLEN-1:0]    rf_wdata,
  output logic                         pc_write_en,
  output logic [XLEN-1:0]              pc_write,
  input  logic                         bypass_freeze,
  output logic [BYPASS_DEPTH-1:0]      bypass_valid,
  output logic [BYPASS_DEPTH*5-1:0]    bypass_rd,
  output logic [BYPASS_DEPTH*XLEN-1:0] bypass_data,
  output logic                         done_executing
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]                  retired_count
`endif
);

  wb_state_e                       state_q, state_d;
  logic                            stg_valid_q, stg_valid_d;
  wb_lane_t      [NUM_LANES-1:0]   stg_q, stg_d, lanes_in;
  bypass_entry_t [BYPASS_DEPTH-1:0] hist_q, hist_d;

  logic                            accept, commit, end_hit, pc_en;
  logic          [NUM_LANES-1:0]   we;
  reg_idx_t      [NUM_LANES-1:0]   waddr;
  double_word    [NUM_LANES-1:0]   wdata;
  double_word                      pc_tgt;
`ifdef WB_RETIRE_COUNT_EN
  logic          [NUM_LANES-1:0]   survive;
  logic          [63:0]            retired_count_q, retired_count_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes_in[i].valid         = in_lane_valid[i];
      lanes_in[i].result        = in_result[i*XLEN +: XLEN];
      lanes_in[i].result_plus_4 = in_result_plus_4[i*XLEN +: XLEN];
      lanes_in[i].is_branch     = in_is_branch[i];
      lanes_in[i].write_rd      = in_write_rd[i];
      lanes_in[i].rd            = in_rd[i*5 +: 5];
      lanes_in[i].end_program   = in_end_program[i];
    end
  end

  assign in_ready = (state_q == RUN) && (!stg_valid_q || rf_grant);
  assign accept   = in_valid && in_ready;
  assign commit   = stg_valid_q && rf_grant && (state_q == RUN);

  wb_lane_resolver #(.NUM_LANES(NUM_LANES)) u_resolver (
    .lanes       (stg_q),
    .commit      (commit),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .pc_write_en (pc_en),
    .pc_write    (pc_tgt),
    .end_hit     (end_hit),
`ifdef WB_RETIRE_COUNT_EN
    .survive     (survive)
`else
    .survive     ()
`endif
  );

  always_comb begin
    state_d     = state_q;
    stg_valid_d = stg_valid_q;
    stg_d       = stg_q;
    hist_d      = hist_q;
    if (commit) stg_valid_d = 1'b0;
    if (accept) begin
      stg_valid_d = 1'b1;
      stg_d       = lanes_in;
    end
    if (end_hit) state_d = DONE;
    // Lane 0 is pushed first, so the youngest written lane ends up at entry 0.
    if (commit && !bypass_freeze) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) begin
          for (int j = BYPASS_DEPTH-1; j > 0; j--) hist_d[j] = hist_d[j-1];
          hist_d[0].valid = 1'b1;
          hist_d[0].rd    = waddr[i];
          hist_d[0].data  = wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for all state. The stage register is reset
    // too (not only its valid bit) so a dropped bundle never leaks stale fields.
    if (!rst) begin
      state_q     <= RUN;
      stg_valid_q <= 1'b0;
      stg_q       <= '0;
      hist_q      <= '0;
    end else begin
      state_q     <= state_d;
      stg_valid_q <= stg_valid_d;
      stg_q       <= stg_d;
      hist_q      <= hist_d;
    end
  end

  always_comb begin
    rf_we       = we;
    pc_write_en = pc_en;
    pc_write    = pc_tgt;
    for (int i = 0; i < NUM_LANES; i++) begin
      rf_waddr[i*5 +: 5]       = waddr[i];
      rf_wdata[i*XLEN +: XLEN] = wdata[i];
    end
    for (int e = 0; e < BYPASS_DEPTH; e++) begin
      bypass_valid[e]             = hist_q[e].valid;
      bypass_rd[e*5 +: 5]         = hist_q[e].rd;
      bypass_data[e*XLEN +: XLEN] = hist_q[e].data;
    end
  end

  assign done_executing = (state_q == DONE);

`ifdef WB_RETIRE_COUNT_EN
  always_comb begin
    retired_count_d = retired_count_q;
    if (commit) retired_count_d = retired_count_q + 64'($countones(survive));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired_count_q <= '0;
    else      retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`endif

endmodule
